// File: rtl/ahb3lite_mem_tester.sv
`default_nettype none
// ============================================================================
// Module      : ahb3lite_mem_tester
// Description : AHB3-Lite bus master that writes a per-beat pattern over a
//               memory range, reads it back and counts mismatches/bus errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ahb3lite_mem_tester #(
    parameter int                    HADDR_SIZE = 20,
    parameter int                    HDATA_SIZE = 32,
    parameter int                    CNT_SIZE   = 16,
    parameter logic [HDATA_SIZE-1:0] PATTERN    = HDATA_SIZE'(32'hA5C3_0000)
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  start,
    input  logic [HADDR_SIZE-1:0] cfg_base,
    input  logic [CNT_SIZE-1:0]   cfg_count,
    input  logic [2:0]            cfg_size,
    input  logic                  cfg_burst,
    input  logic [1:0]            cfg_mode,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CNT_SIZE-1:0]   err_cnt,
    output logic [HADDR_SIZE-1:0] err_addr,
    output logic                  HSEL,
    output logic [1:0]            HTRANS,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HWRITE,
    output logic                  HMASTLOCK,
    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam int         NBYTES    = HDATA_SIZE / 8;
    localparam int         LANE_BITS = $clog2(NBYTES);
    localparam logic [2:0] MAX_SIZE  = 3'(LANE_BITS);

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;
    localparam logic [1:0] TR_SEQ    = 2'b11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_RD    = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // Seed for beat idx, replicated so every byte lane of the bus carries it.
    function automatic logic [HDATA_SIZE-1:0] beat_pattern(
        input logic [CNT_SIZE-1:0] idx,
        input logic [2:0]          sz
    );
        logic [HDATA_SIZE-1:0] seed;
        logic [HDATA_SIZE-1:0] rep;
        int                    lane;
        seed = PATTERN ^ HDATA_SIZE'(idx);
        rep  = '0;
        for (int b = 0; b < NBYTES; b++) begin
            lane            = b & ((1 << sz) - 1);
            rep[8*b +: 8]   = seed[8*lane +: 8];
        end
        return rep;
    endfunction

    function automatic logic [HDATA_SIZE-1:0] lane_mask(
        input logic [LANE_BITS-1:0] off,
        input logic [2:0]           sz
    );
        logic [HDATA_SIZE-1:0] m;
        m = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if ((LANE_BITS'(b) >> sz) == (off >> sz)) begin
                m[8*b +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [HADDR_SIZE-1:0] base_q, base_d;
    logic [CNT_SIZE-1:0]   n_q, n_d;
    logic [2:0]            size_q, size_d;
    logic                  burst_q, burst_d;
    logic                  wr_only_q, wr_only_d;
    logic [CNT_SIZE-1:0]   acnt_q, acnt_d;
    logic                  dp_valid_q, dp_valid_d;
    logic [CNT_SIZE-1:0]   dp_idx_q, dp_idx_d;
    logic [HADDR_SIZE-1:0] dp_addr_q, dp_addr_d;
    logic [CNT_SIZE-1:0]   err_cnt_q, err_cnt_d;
    logic [HADDR_SIZE-1:0] err_addr_q, err_addr_d;

    logic                  w_start_ok;
    logic [CNT_SIZE-1:0]   w_cfg_n;
    logic [2:0]            w_cfg_size;
    logic                  w_in_xfer;
    logic                  w_ap_active;
    logic [HADDR_SIZE-1:0] w_ap_addr;
    logic                  w_dp_done;
    logic                  w_last_dp;
    logic                  w_err_first;
    logic                  w_mismatch;
    logic [HDATA_SIZE-1:0] w_dp_pattern;

    assign w_start_ok   = start && (state_q == S_IDLE || state_q == S_DONE);
    assign w_cfg_n      = cfg_burst ? {cfg_count[CNT_SIZE-1:2], 2'b00} : cfg_count;
    assign w_cfg_size   = (cfg_size > MAX_SIZE) ? MAX_SIZE : cfg_size;
    assign w_in_xfer    = (state_q == S_WR) || (state_q == S_RD);
    assign w_ap_active  = w_in_xfer && (acnt_q != n_q);
    assign w_ap_addr    = base_q + (HADDR_SIZE'(acnt_q) << size_q);
    assign w_dp_done    = dp_valid_q && HREADY;
    assign w_last_dp    = w_dp_done && (dp_idx_q == n_q - CNT_SIZE'(1));
    // First cycle of the two-cycle ERROR response; the second has HREADY=1.
    assign w_err_first  = w_in_xfer && dp_valid_q && HRESP && !HREADY;
    assign w_dp_pattern = beat_pattern(dp_idx_q, size_q);
    assign w_mismatch   = (state_q == S_RD) && w_dp_done && !HRESP &&
                          (|((HRDATA ^ w_dp_pattern) &
                             lane_mask(dp_addr_q[LANE_BITS-1:0], size_q)));

    // State register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    if (w_cfg_n == '0) begin
                        state_d = S_DONE;
                    end else if (cfg_mode == 2'd2) begin
                        state_d = S_RD;
                    end else begin
                        state_d = S_WR;
                    end
                end
            end
            S_WR: begin
                if (w_err_first) begin
                    state_d = S_DRAIN;
                end else if (w_last_dp) begin
                    state_d = wr_only_q ? S_DONE : S_GAP;
                end
            end
            S_GAP:   state_d = S_RD;
            S_RD: begin
                if (w_err_first) begin
                    state_d = S_DRAIN;
                end else if (w_last_dp) begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (HREADY) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            base_q     <= '0;
            n_q        <= '0;
            size_q     <= '0;
            burst_q    <= 1'b0;
            wr_only_q  <= 1'b0;
            acnt_q     <= '0;
            dp_valid_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_addr_q  <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            base_q     <= base_d;
            n_q        <= n_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            wr_only_q  <= wr_only_d;
            acnt_q     <= acnt_d;
            dp_valid_q <= dp_valid_d;
            dp_idx_q   <= dp_idx_d;
            dp_addr_q  <= dp_addr_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    always_comb begin
        base_d     = base_q;
        n_d        = n_q;
        size_d     = size_q;
        burst_d    = burst_q;
        wr_only_d  = wr_only_q;
        acnt_d     = acnt_q;
        dp_valid_d = dp_valid_q;
        dp_idx_d   = dp_idx_q;
        dp_addr_d  = dp_addr_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;

        if (w_start_ok) begin
            base_d     = cfg_base;
            n_d        = w_cfg_n;
            size_d     = w_cfg_size;
            burst_d    = cfg_burst;
            wr_only_d  = (cfg_mode == 2'd1);
            acnt_d     = '0;
            dp_valid_d = 1'b0;
            err_cnt_d  = '0;
            err_addr_d = '0;
        end else begin
            if (state_q == S_GAP) begin
                acnt_d = '0;
            end
            // The beat on the address bus during an error is never accepted.
            if (w_err_first) begin
                dp_valid_d = 1'b0;
            end else if (w_in_xfer && HREADY) begin
                dp_valid_d = w_ap_active;
                if (w_ap_active) begin
                    dp_idx_d  = acnt_q;
                    dp_addr_d = w_ap_addr;
                    acnt_d    = acnt_q + CNT_SIZE'(1);
                end
            end
            if (w_err_first || w_mismatch) begin
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + CNT_SIZE'(1);
                end
                if (err_cnt_q == '0) begin
                    err_addr_d = dp_addr_q;
                end
            end
        end
    end

    // Output logic
    always_comb begin
        HSEL      = w_ap_active;
        HTRANS    = TR_IDLE;
        HADDR     = '0;
        HSIZE     = 3'b000;
        HBURST    = 3'b000;
        HWRITE    = 1'b0;
        if (w_ap_active) begin
            HTRANS = (burst_q && (acnt_q[1:0] != 2'b00)) ? TR_SEQ : TR_NONSEQ;
            HADDR  = w_ap_addr;
            HSIZE  = size_q;
            HBURST = burst_q ? 3'b011 : 3'b000;
            HWRITE = (state_q == S_WR);
        end
        HWDATA    = (state_q == S_WR && dp_valid_q) ? w_dp_pattern : '0;
        HPROT     = 4'b0011;
        HMASTLOCK = 1'b0;
        busy      = (state_q == S_WR) || (state_q == S_GAP) ||
                    (state_q == S_RD) || (state_q == S_DRAIN);
        done      = (state_q == S_DONE);
        pass      = (state_q == S_DONE) && (err_cnt_q == '0);
        err_cnt   = err_cnt_q;
        err_addr  = err_addr_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_mem_tester.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for ahb3lite_mem_tester: memory slave model with wait/error/corrupt
// injection, table of directed tests, plus reset and start-while-busy sequences.
module tb_ahb3lite_mem_tester;

    logic        HCLK, HRESETn, start;
    logic [19:0] cfg_base;
    logic [15:0] cfg_count;
    logic [2:0]  cfg_size;
    logic        cfg_burst;
    logic [1:0]  cfg_mode;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [19:0] err_addr;
    logic        HSEL, HWRITE, HMASTLOCK;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [19:0] HADDR;
    logic [31:0] HWDATA, HRDATA;
    logic        HREADY, HRESP;

    ahb3lite_mem_tester dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
        .cfg_base(cfg_base), .cfg_count(cfg_count), .cfg_size(cfg_size),
        .cfg_burst(cfg_burst), .cfg_mode(cfg_mode),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_addr(err_addr),
        .HSEL(HSEL), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HWRITE(HWRITE), .HMASTLOCK(HMASTLOCK), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_chk, n_fail;

    // current-test settings seen by the slave and the monitor
    logic [19:0] t_base, t_cor_addr;
    logic [2:0]  t_sz;
    logic        t_burst, t_rnd, t_cor_en, t_err_en;
    logic [1:0]  t_mode;
    int          t_n, t_waits, t_err_idx, t_wr0, t_rd0;

    // ---------------- memory slave ----------------
    logic        s_valid, s_write;
    logic [19:0] s_addr;
    logic [2:0]  s_size;
    logic [1:0]  s_errst;
    int          s_wait, s_idx, wr_seen, rd_seen;
    logic [7:0]  mem [0:1023];
    logic [9:0]  s_word;

    assign s_word = {s_addr[9:2], 2'b00};

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        if (s_valid) begin
            if (s_errst == 2'd1) begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end else if (s_errst == 2'd2) begin
                HRESP  = 1'b1;
            end else if (s_wait != 0) begin
                HREADY = 1'b0;
            end
        end
    end

    always_comb begin
        HRDATA = {mem[s_word + 10'd3], mem[s_word + 10'd2], mem[s_word + 10'd1], mem[s_word]};
        if (s_valid && !s_write && t_cor_en && s_addr == t_cor_addr)
            HRDATA[8*int'(s_addr[1:0])] = ~HRDATA[8*int'(s_addr[1:0])];
    end

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_valid <= 1'b0; s_write <= 1'b0; s_addr <= '0; s_size <= '0;
            s_errst <= 2'd0; s_wait <= 0; s_idx <= 0;
            for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        end else begin
            if (s_valid) begin
                if (s_errst == 2'd1) s_errst <= 2'd2;
                else if (s_errst == 2'd2) s_errst <= 2'd0;
                else if (s_wait != 0) s_wait <= s_wait - 1;
                else if (s_write)
                    for (int j = 0; j < (1 << s_size); j++)
                        mem[s_addr[9:0] + 10'(j)] <= HWDATA[8*(int'(s_addr[1:0]) + j) +: 8];
            end
            if (HREADY) begin
                if (HSEL && HTRANS[1]) begin
                    s_valid <= 1'b1; s_addr <= HADDR; s_write <= HWRITE; s_size <= HSIZE;
                    s_wait  <= t_rnd ? int'($urandom_range(32'(t_waits), 0)) : t_waits;
                    if (HWRITE) begin
                        s_idx   <= wr_seen - t_wr0;
                        s_errst <= (t_err_en && (wr_seen - t_wr0) == t_err_idx) ? 2'd1 : 2'd0;
                        wr_seen <= wr_seen + 1;
                    end else begin
                        s_idx   <= rd_seen - t_rd0;
                        s_errst <= 2'd0;
                        rd_seen <= rd_seen + 1;
                    end
                end else begin
                    s_valid <= 1'b0;
                    s_errst <= 2'd0;
                end
            end
        end
    end

    initial begin
        wr_seen = 0;
        rd_seen = 0;
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_pat(input int n, input logic [2:0] s);
        logic [31:0] p;
        p = 32'hA5C3_0000 ^ 32'(n);
        case (s)
            3'd0:    return {4{p[7:0]}};
            3'd1:    return {2{p[15:0]}};
            default: return p;
        endcase
    endfunction

    task automatic monitor();
        int          kw, kr, k;
        logic        is_wr;
        logic [19:0] ea;
        logic [1:0]  et;
        kw = wr_seen - t_wr0;
        kr = rd_seen - t_rd0;
        if (HTRANS != 2'b00) begin
            is_wr = (t_mode != 2'd2) && (kw < t_n);
            k     = is_wr ? kw : kr;
            ea    = t_base + 20'(k << t_sz);
            et    = (t_burst && (k % 4 != 0)) ? 2'b11 : 2'b10;
            chk("addr_phase", {HSEL, HWRITE, HTRANS, HSIZE, HBURST, HPROT, HMASTLOCK, HADDR},
                {1'b1, is_wr, et, t_sz, (t_burst ? 3'b011 : 3'b000), 4'b0011, 1'b0, ea});
        end else begin
            chk("hsel_idle", HSEL, 0);
        end
        if (s_valid && s_write && s_errst == 2'd0) chk("hwdata", HWDATA, exp_pat(s_idx, t_sz));
        if (s_errst == 2'd2) chk("cancel_idle", HTRANS, 0);
    endtask

    typedef struct {
        logic [19:0] base;  logic [15:0] count; logic [2:0] size; logic burst; logic [1:0] mode;
        int waits; logic rnd; logic cor_en; logic [19:0] cor_addr; logic err_en; int err_idx;
        logic exp_pass; logic [15:0] exp_err; logic [19:0] exp_eaddr; int exp_wr; int exp_rd;
        logic poke;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic run_vec(input int id, input vec_t v);
        int cyc;
        @(negedge HCLK);
        t_base = v.base; t_sz = (v.size > 3'd2) ? 3'd2 : v.size; t_burst = v.burst;
        t_mode = v.mode; t_n = v.burst ? int'(v.count & 16'hFFFC) : int'(v.count);
        t_waits = v.waits; t_rnd = v.rnd; t_cor_en = v.cor_en; t_cor_addr = v.cor_addr;
        t_err_en = v.err_en; t_err_idx = v.err_idx; t_wr0 = wr_seen; t_rd0 = rd_seen;
        cfg_base = v.base; cfg_count = v.count; cfg_size = v.size;
        cfg_burst = v.burst; cfg_mode = v.mode; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        if (t_n == 0) chk($sformatf("v%0d_n0_done_next", id), {done, busy}, 2'b10);
        else          chk($sformatf("v%0d_busy_next", id), {done, busy}, 2'b01);
        cyc = 0;
        while (!done && cyc < 3000) begin
            monitor();
            @(negedge HCLK);
            cyc++;
            if (v.poke && cyc == 3) begin
                cfg_base = 20'h300; cfg_count = 16'd2; cfg_mode = 2'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        chk($sformatf("v%0d_timeout", id), cyc < 3000, 1);
        chk($sformatf("v%0d_pass", id), pass, v.exp_pass);
        chk($sformatf("v%0d_err_cnt", id), err_cnt, v.exp_err);
        chk($sformatf("v%0d_err_addr", id), err_addr, v.exp_eaddr);
        chk($sformatf("v%0d_wr_beats", id), wr_seen - t_wr0, v.exp_wr);
        chk($sformatf("v%0d_rd_beats", id), rd_seen - t_rd0, v.exp_rd);
        repeat (2) @(negedge HCLK);
        chk($sformatf("v%0d_done_hold", id), {done, busy, HSEL}, 3'b100);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        HRESETn = 1'b0; start = 1'b0;
        cfg_base = '0; cfg_count = '0; cfg_size = '0; cfg_burst = 1'b0; cfg_mode = '0;
        t_base = '0; t_sz = '0; t_burst = 1'b0; t_mode = '0; t_n = 0; t_waits = 0;
        t_rnd = 1'b0; t_cor_en = 1'b0; t_cor_addr = '0; t_err_en = 1'b0; t_err_idx = 0;
        t_wr0 = 0; t_rd0 = 0;
        repeat (3) @(negedge HCLK);
        chk("rst_ctrl", {HSEL, HTRANS, HWRITE, HSIZE, HBURST, HMASTLOCK, busy, done, pass}, 0);
        chk("rst_hprot", HPROT, 4'b0011);
        chk("rst_addr_data", {HADDR, HWDATA}, 0);
        chk("rst_err", {err_cnt, err_addr}, 0);
        HRESETn = 1'b1;

        //          base      cnt  sz brst mode wt rnd cor cor_addr err eidx pass err eaddr    wr  rd poke
        vecs[0]  = '{20'h00100, 16'd8,  3'd2, 1'b0, 2'd0, 0, 1'b0, 1'b0, 20'h0,     1'b0, 0, 1'b1, 16'd0, 20'h0,     8,  8, 1'b0};
        vecs[1]  = '{20'h00100, 16'd8,  3'd2, 1'b0, 2'd2, 0, 1'b0, 1'b0, 20'h0,     1'b0, 0, 1'b1, 16'd0, 20'h0,     0,  8, 1'b0};
        vecs[2]  = '{20'h00300, 16'd4,  3'd2, 1'b0, 2'd2, 0, 1'b0, 1'b0, 20'h0,     1'b0, 0, 1'b0, 16'd4, 20'h00300, 0,  4, 1'b0};
        vecs[3]  = '{20'h00100, 16'd8,  3'd2, 1'b0, 2'd0, 1, 1'b0, 1'b1, 20'h00108, 1'b0, 0, 1'b0, 16'd1, 20'h00108, 8,  8, 1'b0};
        vecs[4]  = '{20'h00100, 16'd8,  3'd2, 1'b0, 2'd0, 0, 1'b0, 1'b0, 20'h0,     1'b1, 3, 1'b0, 16'd1, 20'h0010C, 4,  0, 1'b0};
        vecs[5]  = '{20'h00100, 16'd3,  3'd2, 1'b1, 2'd0, 0, 1'b0, 1'b0, 20'h0,     1'b0, 0, 1'b1, 16'd0, 20'h0,     0,  0, 1'b0};
        vecs[6]  = '{20'h00100, 16'd70, 3'd0, 1'b0, 2'd0, 2, 1'b1, 1'b0, 20'h0,     1'b0, 0, 1'b1, 16'd0, 20'h0,     70, 70, 1'b0};
        vecs[7]  = '{20'h00100, 16'd30, 3'd1, 1'b1, 2'd0, 0, 1'b0, 1'b0, 20'h0,     1'b0, 0, 1'b1, 16'd0, 20'h0,     28, 28, 1'b0};
        vecs[8]  = '{20'h00200, 16'd5,  3'd2, 1'b0, 2'd1, 1, 1'b0, 1'b0, 20'h0,     1'b0, 0, 1'b1, 16'd0, 20'h0,     5,  0, 1'b0};
        vecs[9]  = '{20'h00180, 16'd4,  3'd3, 1'b0, 2'd3, 0, 1'b0, 1'b0, 20'h0,     1'b0, 0, 1'b1, 16'd0, 20'h0,     4,  4, 1'b0};
        vecs[10] = '{20'hFFFF8, 16'd4,  3'd2, 1'b1, 2'd0, 0, 1'b0, 1'b0, 20'h0,     1'b0, 0, 1'b1, 16'd0, 20'h0,     4,  4, 1'b0};
        vecs[11] = '{20'h00140, 16'd8,  3'd2, 1'b1, 2'd0, 1, 1'b1, 1'b1, 20'h0014C, 1'b0, 0, 1'b0, 16'd1, 20'h0014C, 8,  8, 1'b0};
        vecs[12] = '{20'h00100, 16'd8,  3'd2, 1'b0, 2'd0, 0, 1'b0, 1'b0, 20'h0,     1'b0, 0, 1'b1, 16'd0, 20'h0,     8,  8, 1'b1};

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // reset asserted mid-test aborts without a later done
        @(negedge HCLK);
        cfg_base = 20'h100; cfg_count = 16'd8; cfg_size = 3'd2; cfg_burst = 1'b0;
        cfg_mode = 2'd0; start = 1'b1;
        @(negedge HCLK);
        start = 1'b0;
        repeat (5) @(negedge HCLK);
        chk("midrst_running", busy, 1);
        HRESETn = 1'b0;
        #1;
        chk("midrst_outputs", {busy, done, pass, HSEL, HTRANS, HWRITE, HPROT}, 9'b0_0000_0011);
        @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (20) @(negedge HCLK);
        chk("midrst_no_done", {done, busy, HTRANS}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
